// File: rtl/pool_result_reader_if.sv
// Output stream from the pool result reader toward the next layer's ifmap loader.
// Show-ahead valid/ready: data and address travel together as one beat.
interface pool_result_reader_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int PADDR_WIDTH = 10
);
   logic                   m_valid_o;
   logic                   m_ready_i;
   logic [DATA_WIDTH-1:0]  m_data_o;
   logic [PADDR_WIDTH-1:0] m_addr_o;

   modport master (
      output m_valid_o,
      output m_data_o,
      output m_addr_o,
      input  m_ready_i
   );

   modport slave (
      input  m_valid_o,
      input  m_data_o,
      input  m_addr_o,
      output m_ready_i
   );
endinterface

// File: rtl/pool_result_reader.sv
// Waits for every pool lane to report last, then streams the SA data / pool address
// BRAM pairs in lockstep through a small show-ahead FIFO.
module pool_result_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int PTR_WIDTH   = 14,
   parameter int PADDR_WIDTH = 10,
   parameter int POOL_NUM    = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [PTR_WIDTH:0]     len_i,
   input  logic [POOL_NUM-1:0]    pool_last_i,
   output logic                   sa_data_rden_o,
   output logic                   pool_address_rden_o,
   output logic [PTR_WIDTH-1:0]   rdptr_o,
   input  logic [DATA_WIDTH-1:0]  sa_data_rdata_i,
   input  logic [PADDR_WIDTH-1:0] pool_address_rdata_i,
   pool_result_reader_if.master   m,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [PTR_WIDTH:0] CNT_ONE  = 1;
   localparam logic [AW:0]        OCC_ONE  = 1;
   localparam logic [AW+1:0]      LOAD_MAX = (AW+2)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT_POOL, READ, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic [PADDR_WIDTH-1:0] addr;
   } entry_t;

   state_t               state, state_nx;
   logic [POOL_NUM-1:0]  mask;
   logic [PTR_WIDTH:0]   len_q;
   logic [PTR_WIDTH:0]   issued;
   logic                 inflight;
   logic                 rden;
   entry_t               fifo [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          occ;
   logic [AW+1:0]        load;
   logic                 push, pop;

   assign push = inflight;
   assign pop  = m.m_valid_o && m.m_ready_i;
   // Reads already in flight count against FIFO space so a capture never overflows.
   assign load = {1'b0, occ} + {{(AW+1){1'b0}}, inflight};

   always_comb begin
      state_nx = state;
      rden     = 1'b0;
      case (state)
         IDLE:      if (start_i) state_nx = WAIT_POOL;
         WAIT_POOL: begin
            if (len_q == '0)  state_nx = DRAIN;
            else if (&mask)   state_nx = READ;
         end
         READ: begin
            if (load < LOAD_MAX) begin
               rden = 1'b1;
               if (issued + CNT_ONE == len_q) state_nx = DRAIN;
            end
         end
         // Finish as soon as the FIFO will be empty after this cycle's pop.
         DRAIN:     if (!inflight && (occ == '0 || (occ == OCC_ONE && pop))) state_nx = DONE;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask     <= '0;
         len_q    <= '0;
         issued   <= '0;
         inflight <= 1'b0;
      end else begin
         mask     <= (state == DONE) ? '0 : (mask | pool_last_i);
         inflight <= rden;
         if (state == IDLE && start_i) len_q <= len_i;
         if (state == DONE)            issued <= '0;
         else if (rden)                issued <= issued + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= '{data: sa_data_rdata_i, addr: pool_address_rdata_i};
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   assign sa_data_rden_o      = rden;
   assign pool_address_rden_o = rden;
   assign rdptr_o             = issued[PTR_WIDTH-1:0];
   assign m.m_valid_o         = (occ != '0);
   assign m.m_data_o          = fifo[rd_ptr].data;
   assign m.m_addr_o          = fifo[rd_ptr].addr;
   assign busy_o              = (state != IDLE);
   assign done_o              = (state == DONE);

endmodule

// File: tb/tb_pool_result_reader.sv
// Bench for pool_result_reader: BRAM model, stream monitor and a job-level reference
// (job of length L must yield exactly BRAM words 0..L-1 in order).
module tb_pool_result_reader;
  localparam int DW = 8, PW = 14, AW = 10, PN = 16;

  logic          clk = 1'b0, rst_n = 1'b1, start_i = 1'b0;
  logic [PW:0]   len_i = '0;
  logic [PN-1:0] pool_last_i = '0;
  logic          sa_rden, pa_rden, busy, done;
  logic [PW-1:0] rdptr;
  logic [DW-1:0] sa_rdata = '0;
  logic [AW-1:0] pa_rdata = '0;

  pool_result_reader_if #(.DATA_WIDTH(DW), .PADDR_WIDTH(AW)) s_if ();

  pool_result_reader #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .PADDR_WIDTH(AW),
                       .POOL_NUM(PN), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .pool_last_i(pool_last_i),
    .sa_data_rden_o(sa_rden), .pool_address_rden_o(pa_rden), .rdptr_o(rdptr),
    .sa_data_rdata_i(sa_rdata), .pool_address_rdata_i(pa_rdata),
    .m(s_if.master), .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM contents are a function of the address and a per-job seed.
  int seed = 0;
  function automatic logic [DW-1:0] dword(int p);
    return 8'((p * 7 + seed) & 255);
  endfunction
  function automatic logic [AW-1:0] aword(int p);
    return 10'((p * 13 + seed * 3 + 5) & 1023);
  endfunction

  always @(posedge clk) if (sa_rden) begin
    sa_rdata <= dword(int'(rdptr));
    pa_rdata <= aword(int'(rdptr));
  end

  // Downstream ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random.
  int rmode = 0;
  initial begin
    int ph;
    ph = 0;
    s_if.m_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       s_if.m_ready_i = (ph % 4 == 0) || (ph % 4 == 3);
        2:       s_if.m_ready_i = 1'($urandom_range(0, 1));
        default: s_if.m_ready_i = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor statistics, owned by the monitor process.
  logic        clr_req = 1'b0;
  int          issued, beats, ptr_bad, rden_bad, occ_bad, stab_bad, done_cnt;
  int          done_cyc, last_beat_cyc, first_beat_cyc, first_rden_cyc;
  logic [17:0] got_q[$];
  logic        stalled;
  logic [17:0] held;

  initial forever begin
    @(negedge clk);
    if (clr_req) begin
      issued = 0; beats = 0; ptr_bad = 0; rden_bad = 0; occ_bad = 0; stab_bad = 0;
      done_cnt = 0; done_cyc = -1; last_beat_cyc = -1; first_beat_cyc = -1;
      first_rden_cyc = -1; stalled = 1'b0; held = '0;
      got_q.delete();
    end else if (rst_n) begin
      if (sa_rden != pa_rden) rden_bad++;
      if (sa_rden) begin
        if (int'(rdptr) != issued) ptr_bad++;
        if (issued == 0) first_rden_cyc = cyc;
        issued++;
        if (issued - beats > 4) occ_bad++;
      end
      if (stalled && (!s_if.m_valid_o || {s_if.m_data_o, s_if.m_addr_o} != held)) stab_bad++;
      stalled = s_if.m_valid_o && !s_if.m_ready_i;
      held    = {s_if.m_data_o, s_if.m_addr_o};
      if (s_if.m_valid_o && s_if.m_ready_i) begin
        got_q.push_back({s_if.m_data_o, s_if.m_addr_o});
        if (beats == 0) first_beat_cyc = cyc;
        beats++;
        last_beat_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  int nchk = 0, npass = 0;
  task automatic chk(string name, int got, int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    @(negedge clk); #1;
    clr_req = 1'b0;
  endtask

  task automatic pulse(input logic [PN-1:0] lanes);
    pool_last_i = lanes;
    tick();
    pool_last_i = '0;
  endtask

  task automatic start_job(input int len);
    start_i = 1'b1;
    len_i   = (PW+1)'(len);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    tick(); tick();
    chk("done_pulse", done_cnt, 1);
  endtask

  task automatic check_job(input int len);
    int bad;
    bad = 0;
    chk("beat_count", beats, len);
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] != {dword(i), aword(i)}) bad++;
    chk("payload", bad, 0);
    chk("issued", issued, len);
    chk("ptr_seq", ptr_bad, 0);
    chk("rden_pair", rden_bad, 0);
    chk("occupancy", occ_bad, 0);
    chk("stall_hold", stab_bad, 0);
    chk("idle_after", int'(busy), 0);
  endtask

  typedef struct {
    int len; int rmode; int prefill;
    int exp_beats; int exp_gap; int exp_first; int exp_span;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int sc, pc, n, len;
    vecs[0] = '{8,  0, 1, 8,  1, 4,  7};
    vecs[1] = '{20, 1, 1, 20, 1, -1, -1};
    vecs[2] = '{1,  0, 0, 1,  1, 8,  0};
    vecs[3] = '{4,  2, 0, 4,  1, -1, -1};
    vecs[4] = '{13, 1, 0, 13, 1, -1, -1};

    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_valid", int'(s_if.m_valid_o), 0);
    chk("rst_rden", int'({sa_rden, pa_rden}), 0);
    chk("rst_rdptr", int'(rdptr), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    chk("rst_payload", int'({s_if.m_data_o, s_if.m_addr_o}), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven jobs (entry 0 is the prefilled len=8 case, entry 1 the 1,0,0,1 stall case).
    for (int v = 0; v < 5; v++) begin
      rmode = vecs[v].rmode;
      seed  = v * 17 + 3;
      tick();
      clear_stats();
      if (vecs[v].prefill != 0) pulse('1);
      sc = cyc;
      start_job(vecs[v].len);
      if (vecs[v].prefill == 0) begin repeat (3) tick(); pulse('1); end
      wait_done(500);
      check_job(vecs[v].exp_beats);
      chk("done_gap", done_cyc - last_beat_cyc, vecs[v].exp_gap);
      if (vecs[v].exp_first >= 0) chk("first_beat", first_beat_cyc - sc, vecs[v].exp_first);
      if (vecs[v].exp_span >= 0)  chk("beat_span", last_beat_cyc - first_beat_cyc, vecs[v].exp_span);
    end

    // Lanes 0..14 are not enough; lane 15 releases the read two cycles later.
    rmode = 0; seed = 101;
    clear_stats();
    start_job(5);
    pulse(16'h7fff);
    repeat (10) tick();
    chk("t2_no_rden", issued, 0);
    pc = cyc;
    pulse(16'h8000);
    wait_done(200);
    chk("t2_rden_lat", first_rden_cyc - pc, 2);
    check_job(5);

    // Zero-length job.
    clear_stats();
    pulse('1);
    sc = cyc;
    start_job(0);
    wait_done(50);
    chk("t4_no_rden", issued, 0);
    chk("t4_done_lat", done_cyc - sc, 3);
    // The mask must be clear again: a new job stalls until lanes report.
    seed = 55;
    clear_stats();
    start_job(2);
    repeat (10) tick();
    chk("t4_mask_cleared", issued, 0);
    pulse('1);
    wait_done(200);
    check_job(2);

    // start_i during READ is ignored.
    seed = 77;
    clear_stats();
    pulse('1);
    start_job(6);
    repeat (2) tick();
    start_i = 1'b1; len_i = 15'd2;
    tick();
    start_i = 1'b0;
    wait_done(200);
    check_job(6);

    // Repeated lane 3 pulses never complete the mask.
    seed = 9;
    clear_stats();
    start_job(3);
    pulse(16'h0008);
    pulse(16'h0008);
    repeat (6) tick();
    chk("t5_lane3_twice", issued, 0);
    pulse(~16'h0008);
    wait_done(200);
    check_job(3);

    // Asynchronous reset in the middle of READ.
    seed = 33;
    clear_stats();
    pulse('1);
    start_job(20);
    n = 0;
    while (beats < 3 && n < 100) begin tick(); n++; end
    chk("t6_reached_3", int'(beats >= 3), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(s_if.m_valid_o), 0);
    chk("t6_rden", int'({sa_rden, pa_rden}), 0);
    chk("t6_rdptr", int'(rdptr), 0);
    chk("t6_busy_done", int'({busy, done}), 0);
    chk("t6_payload", int'({s_if.m_data_o, s_if.m_addr_o}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    seed = 44;
    clear_stats();
    pulse('1);
    start_job(4);
    wait_done(200);
    check_job(4);

    // Random jobs: random lengths, random ready, lanes arriving in random groups.
    rmode = 2;
    for (int k = 0; k < 6; k++) begin
      len  = int'($urandom_range(1, 40));
      seed = int'($urandom_range(0, 255));
      tick();
      clear_stats();
      if ($urandom_range(0, 1) == 1) pulse('1);
      start_job(len);
      for (int j = 0; j < 3; j++) pulse(16'($urandom));
      pulse('1);
      wait_done(2000);
      check_job(len);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
